// File: rtl/ram8n_pkg.sv
// ram8n_pkg: geometry constants shared by the eight-word memory blocks
package ram8n_pkg;
    localparam int RAM8_DEPTH = 8;
    localparam int RAM8_AW = 3;
endpackage

// File: rtl/ram8n_if.sv
// ram8n_if: write data, load strobe, shared address and read data of one memory port
interface ram8n_if
    import ram8n_pkg::*;
#(
    parameter int N = 16
);
    logic [N-1:0] in;
    logic load;
    logic [RAM8_AW-1:0] address;
    logic [N-1:0] out;
    modport master (output in, output load, output address, input out);
    modport slave (input in, input load, input address, output out);
endinterface

// File: rtl/muxn.sv
// muxn: N-bit 2-to-1 multiplexer, b selected when sel is high
module muxn #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sel,
    output logic [N-1:0] y
);
    // plain select; the read tree is built from these
    always_comb y = sel ? b : a;
endmodule

// File: rtl/registern.sv
// registern: N-bit word register with load enable; reset clears and overrides load
module registern #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);
    // hold unless loaded; reset wins so a reset cycle never writes
    always_ff @(posedge clk)
        if (rst) q <= '0;
        else if (load) q <= d;
endmodule

// File: rtl/ram8n.sv
// ram8n: eight-word register memory, one-hot write decode and combinational read tree
module ram8n
    import ram8n_pkg::*;
#(
    parameter int N = 16
) (
    input logic clk,
    input logic rst,
    ram8n_if.slave bus
);
    logic [RAM8_DEPTH-1:0] load_vec;
    logic [N-1:0] words [RAM8_DEPTH];
    logic [N-1:0] l0 [4];
    logic [N-1:0] l1 [2];
    logic [N-1:0] l2;
    for (genvar i = 0; i < RAM8_DEPTH; i++) begin : g_word
        assign load_vec[i] = bus.load & (bus.address == RAM8_AW'(i));
        registern #(.N(N)) u_reg (
            .clk (clk),
            .rst (rst),
            .load(load_vec[i]),
            .d   (bus.in),
            .q   (words[i])
        );
    end
    for (genvar i = 0; i < 4; i++) begin : g_l0
        muxn #(.N(N)) u_mux (
            .a  (words[2*i]),
            .b  (words[2*i+1]),
            .sel(bus.address[0]),
            .y  (l0[i])
        );
    end
    for (genvar i = 0; i < 2; i++) begin : g_l1
        muxn #(.N(N)) u_mux (
            .a  (l0[2*i]),
            .b  (l0[2*i+1]),
            .sel(bus.address[1]),
            .y  (l1[i])
        );
    end
    muxn #(.N(N)) u_l2 (
        .a  (l1[0]),
        .b  (l1[1]),
        .sel(bus.address[2]),
        .y  (l2)
    );
    assign bus.out = l2;
endmodule

// File: tb/tb_ram8n.sv
// tb_ram8n: directed scoreboard bench for the eight-word register memory at N=32
module tb_ram8n;
    typedef struct {
        string name;
        logic [31:0] exp;
    } exp_t;
    logic clk = 1'b0;
    logic rst;
    exp_t sb [$];
    event sample;
    int checks = 0;
    int passed = 0;
    ram8n_if #(.N(32)) bus ();
    ram8n #(.N(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #10 clk = ~clk;
    // monitor: compare every queued expectation against the live read port
    always begin
        @(sample);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (bus.out !== e.exp) $display("FAIL %s got=%h exp=%h [FAILED]", e.name, bus.out, e.exp);
            else passed++;
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string name, input logic [2:0] a, input logic [31:0] exp);
        exp_t e;
        bus.address = a;
        #1;
        e.name = name;
        e.exp = exp;
        sb.push_back(e);
        -> sample;
        #1;
    endtask
    task automatic write(input logic [2:0] a, input logic [31:0] d);
        bus.load = 1'b1;
        bus.address = a;
        bus.in = d;
        tick();
        bus.load = 1'b0;
    endtask
    initial begin
        rst = 1'b1;
        bus.load = 1'b0;
        bus.address = '0;
        bus.in = '0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) check($sformatf("reset_a%0d", i), 3'(i), 32'h0);
        write(3'd3, 32'hAAAA5555);
        for (int i = 0; i < 8; i++) check($sformatf("single_a%0d", i), 3'(i), i == 3 ? 32'hAAAA5555 : 32'h0);
        for (int i = 0; i < 8; i++) write(3'(i), 32'h11111111 * i);
        bus.load = 1'b0;
        bus.in = 32'hFFFFFFFF;
        tick();
        tick();
        for (int i = 0; i < 8; i++) check($sformatf("fill_a%0d", i), 3'(i), 32'h11111111 * i);
        tick();
        bus.load = 1'b1;
        bus.in = 32'h55555555;
        check("rdw_old_a5", 3'd5, 32'h55555555);
        bus.in = 32'hAAAAAAAA;
        tick();
        bus.load = 1'b0;
        check("rdw_new_a5", 3'd5, 32'hAAAAAAAA);
        rst = 1'b1;
        bus.load = 1'b1;
        bus.address = 3'd2;
        bus.in = 32'hDEADBEEF;
        tick();
        rst = 1'b0;
        bus.load = 1'b0;
        for (int i = 0; i < 8; i++) check($sformatf("rst_over_load_a%0d", i), 3'(i), 32'h0);
        write(3'd7, 32'hCAFEF00D);
        @(negedge clk);
        #1;
        check("comb_a7", 3'd7, 32'hCAFEF00D);
        check("comb_a0", 3'd0, 32'h0);
        check("comb_a7_again", 3'd7, 32'hCAFEF00D);
        #5;
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain got=%0d exp=0 [FAILED]", sb.size());
            checks++;
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
